// File: rtl/barrel_pkg.sv
// barrel_pkg: shared definitions for the barrel-processor front end.
// Holds the default thread/address geometry, the scalar tid and address types
// used by the scheduler and the pipeline registers, and the sequential PC step.
package barrel_pkg;

  localparam int ADDR_W      = 32;
  localparam int TID_W       = 3;
  localparam int NUM_THREADS = 2**TID_W;
  localparam int PC_STEP     = 4;

  typedef logic [TID_W-1:0]  tid_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Instruction slot handed from the scheduler to fetch and carried down the pipe.
  typedef struct packed {
    logic  vld;
    tid_t  tid;
    addr_t pc;
  } fetch_req_t;

endpackage

// File: rtl/thread_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first requesting index strictly after ptr, wrapping modulo 2**W,
// so ptr itself is the lowest-priority candidate.
//   req   in  2**W  request mask
//   ptr   in  W     last granted index
//   found out 1     at least one request set
//   idx   out W     chosen index (0 when found=0)
module rr_pick #(
  parameter int W = 3
) (
  input  logic [2**W-1:0] req,
  input  logic [W-1:0]    ptr,
  output logic            found,
  output logic [W-1:0]    idx
);

  localparam int N = 2**W;

  logic [W-1:0] cand;

  // N is a power of two, so the W-bit add wraps for free; i == N lands on ptr.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = ptr + W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// thread_sched: barrel-processor thread scheduler feeding fetch.
// Each non-stalled cycle picks one eligible thread (active, cooldown expired)
// round-robin and registers its PC/tid onto the fetch outputs. Keeps per-thread
// PC, active bit and issue cooldown; absorbs Execute redirects, spawns, halts.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   stall                         pipeline frozen; issue state holds
//   spawn_valid/tid/pc            start a thread at a PC
//   halt_valid/tid                stop a thread
//   redirect_e/tid_e/pc_e         taken branch/jump target from Execute
//   valid_f, pc_f, tid_f          issued slot for fetch
//   active_mask, idle             per-thread active bits, no thread active
//   spawn_err                     pulse: spawn to an already-active thread
//   issue_cnt, bubble_cnt         only with THREAD_SCHED_STATS_EN defined
//
// Optional build macro: THREAD_SCHED_STATS_EN adds issue/bubble counters.
module thread_sched #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       BITS_THREADS  = 3,
  parameter int                       ISSUE_GAP     = 3,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       spawn_valid,
  input  logic [BITS_THREADS-1:0]    spawn_tid,
  input  logic [ADDRESS_WIDTH-1:0]   spawn_pc,
  input  logic                       halt_valid,
  input  logic [BITS_THREADS-1:0]    halt_tid,
  input  logic                       redirect_e,
  input  logic [BITS_THREADS-1:0]    redirect_tid_e,
  input  logic [ADDRESS_WIDTH-1:0]   redirect_pc_e,
  output logic                       valid_f,
  output logic [ADDRESS_WIDTH-1:0]   pc_f,
  output logic [BITS_THREADS-1:0]    tid_f,
  output logic [2**BITS_THREADS-1:0] active_mask,
  output logic                       idle,
`ifdef THREAD_SCHED_STATS_EN
  output logic [31:0]                issue_cnt,
  output logic [31:0]                bubble_cnt,
`endif
  output logic                       spawn_err
);

  import barrel_pkg::*;

  localparam int                NTHR      = 2**BITS_THREADS;
  localparam int                CDW       = 4;
  localparam logic [CDW-1:0]    CD_RELOAD = CDW'(ISSUE_GAP - 1);
  localparam logic [BITS_THREADS-1:0] PTR_RST = BITS_THREADS'(NTHR - 1);

  logic [NTHR-1:0][ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [NTHR-1:0][CDW-1:0]           cd_q, cd_d;
  logic [NTHR-1:0]                    act_q, act_d;
  logic [BITS_THREADS-1:0]            ptr_q, ptr_d;
  logic                               valid_f_q, valid_f_d;
  logic [ADDRESS_WIDTH-1:0]           pc_f_q, pc_f_d;
  logic [BITS_THREADS-1:0]            tid_f_q, tid_f_d;
  logic                               idle_q, idle_d;
  logic                               spawn_err_q, spawn_err_d;

  logic [NTHR-1:0]                    elig;
  logic                               pick_found;
  logic [BITS_THREADS-1:0]            pick_tid;

  for (genvar t = 0; t < NTHR; t++) begin : g_elig
    assign elig[t] = act_q[t] && (cd_q[t] == '0);
  end

  rr_pick #(.W(BITS_THREADS)) u_pick (
    .req   (elig),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_tid)
  );

  // Issue first, then redirect / spawn / halt on top. Selection and all
  // validity checks read the pre-update arrays.
  always_comb begin
    pc_d        = pc_q;
    cd_d        = cd_q;
    act_d       = act_q;
    ptr_d       = ptr_q;
    valid_f_d   = valid_f_q;
    pc_f_d      = pc_f_q;
    tid_f_d     = tid_f_q;
    spawn_err_d = 1'b0;

    if (!stall) begin
      for (int t = 0; t < NTHR; t++) begin
        if (cd_q[t] != '0) cd_d[t] = cd_q[t] - 1'b1;
      end
      valid_f_d = pick_found;
      if (pick_found) begin
        pc_f_d         = pc_q[pick_tid];
        tid_f_d        = pick_tid;
        pc_d[pick_tid] = pc_q[pick_tid] + ADDRESS_WIDTH'(PC_STEP);
        cd_d[pick_tid] = CD_RELOAD;
        ptr_d          = pick_tid;
      end
    end

    // Redirect wins over the +4 of a same-cycle issue.
    if (redirect_e && act_q[redirect_tid_e])
      pc_d[redirect_tid_e] = redirect_pc_e;

    // A halt colliding with a spawn to the same tid is dropped: spawn wins.
    if (halt_valid && !(spawn_valid && (spawn_tid == halt_tid)))
      act_d[halt_tid] = 1'b0;

    if (spawn_valid) begin
      if (act_q[spawn_tid]) begin
        spawn_err_d = 1'b1;
      end else begin
        act_d[spawn_tid] = 1'b1;
        pc_d[spawn_tid]  = spawn_pc;
        cd_d[spawn_tid]  = '0;
      end
    end

    idle_d = ~|act_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      pc_q[0]     <= RESET_PC;
      cd_q        <= '0;
      act_q       <= NTHR'(1);
      ptr_q       <= PTR_RST;
      valid_f_q   <= 1'b0;
      pc_f_q      <= '0;
      tid_f_q     <= '0;
      idle_q      <= 1'b0;
      spawn_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      cd_q        <= cd_d;
      act_q       <= act_d;
      ptr_q       <= ptr_d;
      valid_f_q   <= valid_f_d;
      pc_f_q      <= pc_f_d;
      tid_f_q     <= tid_f_d;
      idle_q      <= idle_d;
      spawn_err_q <= spawn_err_d;
    end
  end

  assign valid_f     = valid_f_q;
  assign pc_f        = pc_f_q;
  assign tid_f       = tid_f_q;
  assign active_mask = act_q;
  assign idle        = idle_q;
  assign spawn_err   = spawn_err_q;

`ifdef THREAD_SCHED_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // A bubble is a lost slot while some thread exists but none is eligible.
  always_comb begin
    issue_cnt_d  = issue_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!stall) begin
      if (pick_found)   issue_cnt_d  = issue_cnt_q + 32'd1;
      else if (!idle_q) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      issue_cnt_q  <= issue_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign issue_cnt  = issue_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_thread_sched.sv
// tb_thread_sched: directed vector table plus randomized run against a
// behavioural model of the scheduler rules (default parameters).
module tb_thread_sched;

  localparam int AW  = 32;
  localparam int TW  = 3;
  localparam int NT  = 8;
  localparam int GAP = 3;

  logic          clk = 1'b0;
  logic          rst, stall, spawn_valid, halt_valid, redirect_e;
  logic [TW-1:0] spawn_tid, halt_tid, redirect_tid_e;
  logic [AW-1:0] spawn_pc, redirect_pc_e;
  logic          valid_f, idle, spawn_err;
  logic [AW-1:0] pc_f;
  logic [TW-1:0] tid_f;
  logic [NT-1:0] active_mask;
`ifdef THREAD_SCHED_STATS_EN
  logic [31:0]   issue_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  thread_sched #(.ADDRESS_WIDTH(AW), .BITS_THREADS(TW), .ISSUE_GAP(GAP), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .spawn_valid(spawn_valid), .spawn_tid(spawn_tid), .spawn_pc(spawn_pc),
    .halt_valid(halt_valid), .halt_tid(halt_tid),
    .redirect_e(redirect_e), .redirect_tid_e(redirect_tid_e), .redirect_pc_e(redirect_pc_e),
    .valid_f(valid_f), .pc_f(pc_f), .tid_f(tid_f),
    .active_mask(active_mask), .idle(idle),
`ifdef THREAD_SCHED_STATS_EN
    .issue_cnt(issue_cnt), .bubble_cnt(bubble_cnt),
`endif
    .spawn_err(spawn_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit ev, input logic [AW-1:0] epc,
                         input int etid, input logic [NT-1:0] emask, input bit eerr);
    chk({tag, ".valid_f"},     64'(valid_f),     64'(ev));
    chk({tag, ".pc_f"},        64'(pc_f),        64'(epc));
    chk({tag, ".tid_f"},       64'(tid_f),       64'(etid));
    chk({tag, ".active_mask"}, 64'(active_mask), 64'(emask));
    chk({tag, ".idle"},        64'(idle),        64'(emask == '0));
    chk({tag, ".spawn_err"},   64'(spawn_err),   64'(eerr));
  endtask

  task automatic drive(input bit st, input bit sv, input int stid, input logic [AW-1:0] spc,
                       input bit hv, input int htid, input bit rv, input int rtid,
                       input logic [AW-1:0] rpc);
    stall = st; spawn_valid = sv; spawn_tid = TW'(stid); spawn_pc = spc;
    halt_valid = hv; halt_tid = TW'(htid);
    redirect_e = rv; redirect_tid_e = TW'(rtid); redirect_pc_e = rpc;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit st; bit sv; int stid; logic [AW-1:0] spc; bit hv; int htid;
    bit rv; int rtid; logic [AW-1:0] rpc;
    bit ev; logic [AW-1:0] epc; int etid; logic [NT-1:0] emask; bit eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit st, bit sv, int stid, logic [AW-1:0] spc, bit hv, int htid,
                              bit rv, int rtid, logic [AW-1:0] rpc,
                              bit ev, logic [AW-1:0] epc, int etid, logic [NT-1:0] emask, bit eerr);
    vec_t v;
    v.st = st; v.sv = sv; v.stid = stid; v.spc = spc; v.hv = hv; v.htid = htid;
    v.rv = rv; v.rtid = rtid; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.etid = etid; v.emask = emask; v.eerr = eerr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [AW-1:0] m_pc [NT];
  bit            m_act[NT];
  int            m_cd [NT];
  int            m_ptr;
  bit            m_valid, m_err;
  logic [AW-1:0] m_pcf;
  int            m_tidf;
  int unsigned   m_issue, m_bubble;

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin m_pc[t] = '0; m_act[t] = 0; m_cd[t] = 0; end
    m_act[0] = 1; m_ptr = NT - 1;
    m_valid = 0; m_pcf = '0; m_tidf = 0; m_err = 0; m_issue = 0; m_bubble = 0;
  endtask

  function automatic logic [NT-1:0] model_mask();
    logic [NT-1:0] m;
    for (int t = 0; t < NT; t++) m[t] = m_act[t];
    return m;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    int  pick = -1;
    bit  any_act = 0;
    int  s = int'(spawn_tid), h = int'(halt_tid), r = int'(redirect_tid_e);
    bit  act_pre[NT];
    for (int t = 0; t < NT; t++) begin act_pre[t] = m_act[t]; if (m_act[t]) any_act = 1; end
    if (!stall) begin
      for (int k = 1; k <= NT; k++) begin
        int t = (m_ptr + k) % NT;
        if (pick < 0 && m_act[t] && m_cd[t] == 0) pick = t;
      end
      for (int t = 0; t < NT; t++) if (t != pick && m_cd[t] > 0) m_cd[t]--;
      if (pick >= 0) begin
        m_valid = 1; m_pcf = m_pc[pick]; m_tidf = pick;
        m_pc[pick] = m_pc[pick] + 4; m_cd[pick] = GAP - 1; m_ptr = pick;
        m_issue++;
      end else begin
        m_valid = 0;
        if (any_act) m_bubble++;
      end
    end
    if (redirect_e && act_pre[r]) m_pc[r] = redirect_pc_e;
    m_err = spawn_valid && act_pre[s];
    if (spawn_valid && !act_pre[s]) begin m_act[s] = 1; m_pc[s] = spawn_pc; m_cd[s] = 0; end
    if (halt_valid && !(spawn_valid && s == h)) m_act[h] = 0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);

    // Single thread, spawns, redirect, stall, spawn_err, halts, spawn+halt.
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h0,  0,'h01,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0,'h0,  0,'h01,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0,'h0,  0,'h01,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h4,  0,'h01,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0,'h4,  0,'h01,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0,'h4,  0,'h01,0));
    tbl.push_back(mk(0,1,1,'h100,  0,0, 0,0,0,        1,'h8,  0,'h03,0));
    tbl.push_back(mk(0,1,2,'h200,  0,0, 0,0,0,        1,'h100,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h200,2,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'hC,  0,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h104,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h204,2,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 1,1,'h400,    1,'h10, 0,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h400,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h208,2,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h14, 0,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h404,1,'h07,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0,0,    0,0, 0,0,0,        1,'h404,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h20C,2,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h18, 0,'h07,0));
    tbl.push_back(mk(0,1,0,'h990,  0,0, 0,0,0,        1,'h408,1,'h07,1));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h210,2,'h07,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h1C, 0,'h07,0));
    tbl.push_back(mk(0,0,0,0,      1,0, 0,0,0,        1,'h40C,1,'h06,0));
    tbl.push_back(mk(0,0,0,0,      1,1, 0,0,0,        1,'h214,2,'h04,0));
    tbl.push_back(mk(0,0,0,0,      1,2, 0,0,0,        0,'h214,2,'h00,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0,'h214,2,'h00,0));
    tbl.push_back(mk(0,1,5,'h80,   0,0, 0,0,0,        0,'h214,2,'h20,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h80, 5,'h20,0));
    tbl.push_back(mk(0,1,3,'h300,  1,3, 0,0,0,        0,'h80, 5,'h28,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h300,3,'h28,0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        1,'h84, 5,'h28,0));

    repeat (3) @(posedge clk);
    #1 chk_out("reset", 0, '0, 0, 'h01, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].sv, tbl[i].stid, tbl[i].spc, tbl[i].hv, tbl[i].htid,
            tbl[i].rv, tbl[i].rtid, tbl[i].rpc);
      @(posedge clk);
      #1 chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].etid, tbl[i].emask, tbl[i].eerr);
      @(negedge clk);
    end

    // Reset mid-stream with a redirect pending: everything but thread 0 is gone.
    rst = 1'b1;
    drive(0, 0, 0, '0, 0, 0, 1, 0, 'h5000);
    @(posedge clk);
    #1 chk_out("midrst", 0, '0, 0, 'h01, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, '0, 0, 0, 0, 0, '0);
    @(posedge clk);
    #1 chk_out("midrst.first", 1, '0, 0, 'h01, 0);
    @(negedge clk);
    @(posedge clk);
    #1 chk_out("midrst.gap", 0, '0, 0, 'h01, 0);
    @(negedge clk);

    // Randomized run against the model.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [AW-1:0] sp;
      sp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      drive($urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 20, $urandom_range(0, NT-1), sp,
            $urandom_range(0, 99) < 12, $urandom_range(0, NT-1),
            $urandom_range(0, 99) < 20, $urandom_range(0, NT-1), $urandom & 32'hFFFF_FFFC);
      model_step();
      @(posedge clk);
      #1 chk_out($sformatf("rnd%0d", c), m_valid, m_pcf, m_tidf, model_mask(), m_err);
`ifdef THREAD_SCHED_STATS_EN
      chk($sformatf("rnd%0d.issue_cnt", c),  64'(issue_cnt),  64'(m_issue));
      chk($sformatf("rnd%0d.bubble_cnt", c), 64'(bubble_cnt), 64'(m_bubble));
`endif
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
